// File: rtl/roubus_wr_arbiter.sv
// Packet-locked round-robin arbiter for the shared async_stage write port.
// Optional idle-holder watchdog enabled by defining ROUBUS_ARB_WATCHDOG_EN.
module roubus_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int WID      = 32,
   parameter int IDW      = 2,
   parameter int MAXBURST = 8,
   parameter int TMO      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       last,
   input  logic [NREQ*WID-1:0]   data,
   output logic [NREQ-1:0]       ack,
   output logic                  stage_writex,
   output logic [IDW+WID-1:0]    stage_wdata,
   input  logic                  stage_wfull,
   output logic                  grant_valid,
   output logic [IDW-1:0]        grant_id,
   output logic                  wdog_err
);

   if (NREQ < 2 || NREQ > 16 || (2**IDW) < NREQ || MAXBURST < 1 || MAXBURST > 255 ||
       TMO < 1 || TMO > 255) begin : g_bad_param
      $error("roubus_wr_arbiter: parameter out of range");
   end

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state;
   logic [IDW-1:0] rr_ptr;
   logic [7:0]     beat_cnt;

   logic           sel_req;
   logic           sel_last;
   logic [WID-1:0] sel_data;
   logic           fire;
   logic           found;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] next_ptr;
   logic           wdog_to;

   always_comb begin
      sel_req  = 1'b0;
      sel_last = 1'b0;
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (IDW'(i) == grant_id) begin
            sel_req  = req[i];
            sel_last = last[i];
            sel_data = data[i*WID +: WID];
         end
      end
   end

   // Two-pass scan: indices at or above rr_ptr first, then wrap to the low ones.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (i >= 32'(rr_ptr))) begin
            found  = 1'b1;
            winner = IDW'(i);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req[i]) begin
            found  = 1'b1;
            winner = IDW'(i);
         end
      end
   end

   assign next_ptr     = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
   assign fire         = (state == BUSY) && sel_req && !stage_wfull;
   assign stage_writex = fire;
   assign stage_wdata  = (state == BUSY) ? {grant_id, sel_data} : '0;

   always_comb begin
      ack = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         ack[i] = fire && (IDW'(i) == grant_id);
      end
   end

`ifdef ROUBUS_ARB_WATCHDOG_EN
   logic [7:0] wdog_cnt;

   // Only cycles with the holder's req low count; full-stalls keep req high.
   assign wdog_to = (state == BUSY) && !sel_req && (wdog_cnt == 8'(TMO-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         wdog_err <= wdog_to;
         if (state != BUSY || sel_req || wdog_to) wdog_cnt <= '0;
         else                                     wdog_cnt <= wdog_cnt + 8'd1;
      end
   end
`else
   assign wdog_to  = 1'b0;
   assign wdog_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         rr_ptr      <= '0;
         beat_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id    <= winner;
                  grant_valid <= 1'b1;
                  beat_cnt    <= '0;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (fire) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (sel_last || beat_cnt == 8'(MAXBURST-1)) begin
                     state       <= IDLE;
                     grant_valid <= 1'b0;
                     rr_ptr      <= next_ptr;
                  end
               end else if (wdog_to) begin
                  state       <= IDLE;
                  grant_valid <= 1'b0;
                  rr_ptr      <= next_ptr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_roubus_wr_arbiter.sv
// Self-checking bench for roubus_wr_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_roubus_wr_arbiter;
   localparam int NREQ     = 4;
   localparam int WID      = 32;
   localparam int IDW      = 2;
   localparam int MAXBURST = 8;
   localparam int TMO      = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     last;
   logic [NREQ*WID-1:0] data;
   logic [NREQ-1:0]     ack;
   logic                stage_writex;
   logic [IDW+WID-1:0]  stage_wdata;
   logic                stage_wfull;
   logic                grant_valid;
   logic [IDW-1:0]      grant_id;
   logic                wdog_err;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   roubus_wr_arbiter #(
      .NREQ(NREQ), .WID(WID), .IDW(IDW), .MAXBURST(MAXBURST), .TMO(TMO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .last(last), .data(data), .ack(ack),
      .stage_writex(stage_writex), .stage_wdata(stage_wdata), .stage_wfull(stage_wfull),
      .grant_valid(grant_valid), .grant_id(grant_id), .wdog_err(wdog_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; last = '0; data = '0; stage_wfull = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '1; last = '1; data = '1; stage_wfull = 1'b0;
      tick();
      tick();
      #4;
      n_total++; if (grant_valid !== 1'b0) $display("FAIL reset_gv: got %0b want 0", grant_valid); else n_pass++;
      n_total++; if (grant_id !== '0) $display("FAIL reset_gid: got %0d want 0", grant_id); else n_pass++;
      n_total++; if (ack !== '0) $display("FAIL reset_ack: got %b want 0", ack); else n_pass++;
      n_total++; if (stage_writex !== 1'b0) $display("FAIL reset_wx: got %0b want 0", stage_writex); else n_pass++;
      n_total++; if (stage_wdata !== '0) $display("FAIL reset_wdata: got %0h want 0", stage_wdata); else n_pass++;
      n_total++; if (wdog_err !== 1'b0) $display("FAIL reset_wdog: got %0b want 0", wdog_err); else n_pass++;
      tick();
      rst = 1'b0; req = '0; last = '0; data = '0;
   endtask

   task automatic test_two_req();
      logic [WID-1:0] d [NREQ];
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         d[i] = $urandom;
         data[i*WID +: WID] = d[i];
      end
      req = 4'b0101; last = 4'b0101;
      #4;
      n_total++; if (grant_valid !== 1'b0 || ack !== '0) $display("FAIL two_arb: got gv=%0b ack=%b want gv=0 ack=0", grant_valid, ack); else n_pass++;
      tick(); #4;
      n_total++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) $display("FAIL two_g0: got gv=%0b id=%0d want gv=1 id=0", grant_valid, grant_id); else n_pass++;
      n_total++; if (ack !== 4'b0001 || stage_writex !== 1'b1) $display("FAIL two_ack0: got ack=%b wx=%0b want 0001/1", ack, stage_writex); else n_pass++;
      n_total++; if (stage_wdata !== {2'd0, d[0]}) $display("FAIL two_wd0: got %0h want %0h", stage_wdata, {2'd0, d[0]}); else n_pass++;
      tick();
      req = 4'b0100; last = 4'b0100;
      #4;
      n_total++; if (grant_valid !== 1'b0 || ack !== '0) $display("FAIL two_gap: got gv=%0b ack=%b want 0/0", grant_valid, ack); else n_pass++;
      tick(); #4;
      n_total++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) $display("FAIL two_g2: got gv=%0b id=%0d want gv=1 id=2", grant_valid, grant_id); else n_pass++;
      n_total++; if (ack !== 4'b0100 || stage_wdata !== {2'd2, d[2]}) $display("FAIL two_ack2: got ack=%b wd=%0h want 0100/%0h", ack, stage_wdata, {2'd2, d[2]}); else n_pass++;
      tick();
      req = 4'b1001; last = 4'b1001;
      #4;
      n_total++; if (grant_valid !== 1'b0) $display("FAIL two_gap2: got gv=%0b want 0", grant_valid); else n_pass++;
      tick(); #4;
      n_total++; if (grant_id !== 2'd3 || ack !== 4'b1000) $display("FAIL two_ptr3: got id=%0d ack=%b want 3/1000", grant_id, ack); else n_pass++;
      tick();
      req = '0; last = '0;
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      req = 4'b0010; last = '0; data[WID +: WID] = 32'hA1;
      #4;
      n_total++; if (grant_valid !== 1'b0) $display("FAIL stall_arb: got gv=%0b want 0", grant_valid); else n_pass++;
      tick(); #4;
      n_total++; if (ack !== 4'b0010 || stage_wdata !== {2'd1, 32'hA1}) $display("FAIL stall_b1: got ack=%b wd=%0h want 0010/%0h", ack, stage_wdata, {2'd1, 32'hA1}); else n_pass++;
      tick();
      data[WID +: WID] = 32'hA2; stage_wfull = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #4;
         n_total++; if (ack !== '0 || stage_writex !== 1'b0) $display("FAIL stall_full%0d: got ack=%b wx=%0b want 0/0", k, ack, stage_writex); else n_pass++;
         n_total++; if (grant_valid !== 1'b1 || stage_wdata !== {2'd1, 32'hA2}) $display("FAIL stall_hold%0d: got gv=%0b wd=%0h want 1/%0h", k, grant_valid, stage_wdata, {2'd1, 32'hA2}); else n_pass++;
         tick();
      end
      stage_wfull = 1'b0;
      #4;
      n_total++; if (ack !== 4'b0010 || stage_wdata !== {2'd1, 32'hA2}) $display("FAIL stall_b2: got ack=%b wd=%0h want 0010/%0h", ack, stage_wdata, {2'd1, 32'hA2}); else n_pass++;
      tick();
      data[WID +: WID] = 32'hA3; last = 4'b0010;
      #4;
      n_total++; if (ack !== 4'b0010 || stage_writex !== 1'b1 || stage_wdata !== {2'd1, 32'hA3}) $display("FAIL stall_b3: got ack=%b wx=%0b wd=%0h want 0010/1/%0h", ack, stage_writex, stage_wdata, {2'd1, 32'hA3}); else n_pass++;
      tick();
      req = '0; last = '0;
      #4;
      n_total++; if (grant_valid !== 1'b0) $display("FAIL stall_rel: got gv=%0b want 0", grant_valid); else n_pass++;
      tick();
   endtask

   task automatic test_all_rr();
      int ids[$];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      logic prev = 1'b0;
      do_reset();
      req = '1; last = '1;
      for (int i = 0; i < NREQ; i++) data[i*WID +: WID] = $urandom;
      for (int c = 0; c < 12 && ids.size() < 5; c++) begin
         #4;
         if (grant_valid === 1'b1) begin
            ids.push_back(int'(grant_id));
            n_total++; if (ack !== (4'b0001 << grant_id)) $display("FAIL rr_ack: got %b want %b", ack, 4'b0001 << grant_id); else n_pass++;
            n_total++; if (prev !== 1'b0) $display("FAIL rr_len: got grant spanning 2 cycles want 1 beat"); else n_pass++;
         end
         prev = grant_valid;
         tick();
      end
      n_total++; if (ids.size() != 5) $display("FAIL rr_count: got %0d grants want 5", ids.size()); else n_pass++;
      for (int k = 0; k < ids.size(); k++) begin
         n_total++; if (ids[k] != exp_order[k]) $display("FAIL rr_order%0d: got %0d want %0d", k, ids[k], exp_order[k]); else n_pass++;
      end
      req = '0; last = '0;
      tick();
   endtask

   task automatic test_maxburst();
      int log_ids[$];
      int exp_ids[$];
      int unsigned beats3 = 0;
      logic done0 = 1'b0;
      logic [IDW+WID-1:0] exp_wd;
      do_reset();
      for (int c = 0; c < 60 && !(beats3 == 12 && done0); c++) begin
         req[3] = (beats3 < 12);
         last[3] = 1'b0;
         data[3*WID +: WID] = 32'h300 + beats3;
         req[0] = (c >= 2) && !done0;
         last[0] = 1'b1;
         data[0 +: WID] = 32'h0C0;
         #4;
         if (ack !== '0) begin
            if (ack === 4'b1000) begin
               exp_wd = {2'd3, 32'h300 + beats3};
               log_ids.push_back(3);
               beats3++;
            end else if (ack === 4'b0001) begin
               exp_wd = {2'd0, 32'h0C0};
               log_ids.push_back(0);
               done0 = 1'b1;
            end else begin
               exp_wd = '0;
               log_ids.push_back(-1);
            end
            n_total++; if (stage_wdata !== exp_wd) $display("FAIL mb_wdata: got %0h want %0h (ack=%b)", stage_wdata, exp_wd, ack); else n_pass++;
         end
         tick();
      end
      for (int k = 0; k < 8; k++) exp_ids.push_back(3);
      exp_ids.push_back(0);
      for (int k = 0; k < 4; k++) exp_ids.push_back(3);
      n_total++; if (log_ids.size() != exp_ids.size()) $display("FAIL mb_count: got %0d beats want %0d", log_ids.size(), exp_ids.size()); else n_pass++;
      for (int k = 0; k < log_ids.size() && k < exp_ids.size(); k++) begin
         n_total++; if (log_ids[k] != exp_ids[k]) $display("FAIL mb_seq%0d: got id %0d want %0d", k, log_ids[k], exp_ids[k]); else n_pass++;
      end
      req = '0; last = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0010; last = 4'b0010;
      tick();
      tick();
      req = 4'b0100; last = '0;
      tick();
      for (int b = 1; b <= 2; b++) begin
         data[2*WID +: WID] = 32'h200 + b;
         tick();
      end
      data[2*WID +: WID] = 32'h203;
      #4;
      n_total++; if (ack !== 4'b0100 || grant_id !== 2'd2) $display("FAIL rm_pre: got ack=%b id=%0d want 0100/2", ack, grant_id); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (grant_valid !== 1'b0 || stage_writex !== 1'b0) $display("FAIL rm_drop: got gv=%0b wx=%0b want 0/0", grant_valid, stage_writex); else n_pass++;
      n_total++; if (ack !== '0 || stage_wdata !== '0) $display("FAIL rm_out: got ack=%b wd=%0h want 0/0", ack, stage_wdata); else n_pass++;
      tick();
      rst = 1'b0; req = 4'b0110; last = 4'b0110;
      #4;
      n_total++; if (grant_valid !== 1'b0) $display("FAIL rm_idle: got gv=%0b want 0", grant_valid); else n_pass++;
      tick(); #4;
      n_total++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) $display("FAIL rm_ptr: got gv=%0b id=%0d want 1/1", grant_valid, grant_id); else n_pass++;
      tick();
      req = '0; last = '0;
      tick();
   endtask

   task automatic test_wfull_long();
      do_reset();
      req = 4'b0011; last = '0;
      tick();
      stage_wfull = 1'b1;
      for (int c = 0; c < 40; c++) begin
         #4;
         n_total++;
         if ({grant_valid, grant_id, ack, wdog_err} !== {1'b1, 2'd0, 4'b0000, 1'b0})
            $display("FAIL wfl_hold%0d: got gv=%0b id=%0d ack=%b wd=%0b want 1/0/0000/0", c, grant_valid, grant_id, ack, wdog_err);
         else n_pass++;
         tick();
      end
      stage_wfull = 1'b0; last = 4'b0001;
      #4;
      n_total++; if (ack !== 4'b0001) $display("FAIL wfl_go: got ack=%b want 0001", ack); else n_pass++;
      tick();
      req = '0; last = '0;
      #4;
      n_total++; if (grant_valid !== 1'b0) $display("FAIL wfl_rel: got gv=%0b want 0", grant_valid); else n_pass++;
      tick();
   endtask

`ifdef ROUBUS_ARB_WATCHDOG_EN
   task automatic test_watchdog();
      int unsigned n = 0;
      do_reset();
      req = 4'b0011; last = '0;
      tick(); #4;
      n_total++; if (ack !== 4'b0001) $display("FAIL wd_beat: got ack=%b want 0001", ack); else n_pass++;
      tick();
      req = 4'b0010;
      #4;
      while (wdog_err !== 1'b1 && n < 40) begin
         tick();
         n++;
         #4;
      end
      n_total++; if (n != 16) $display("FAIL wd_delay: got %0d cycles want 16", n); else n_pass++;
      n_total++; if (grant_valid !== 1'b0) $display("FAIL wd_rel: got gv=%0b want 0", grant_valid); else n_pass++;
      tick(); #4;
      n_total++; if (wdog_err !== 1'b0) $display("FAIL wd_pulse: got %0b want 0", wdog_err); else n_pass++;
      n_total++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) $display("FAIL wd_next: got gv=%0b id=%0d want 1/1", grant_valid, grant_id); else n_pass++;
      req = '0;
      tick();
   endtask
`else
   task automatic test_idle_holder();
      do_reset();
      req = 4'b0011; last = '0;
      tick();
      tick();
      req = 4'b0010;
      for (int c = 0; c < 40; c++) begin
         #4;
         n_total++;
         if ({grant_valid, grant_id, ack, wdog_err} !== {1'b1, 2'd0, 4'b0000, 1'b0})
            $display("FAIL ih_hold%0d: got gv=%0b id=%0d ack=%b wd=%0b want 1/0/0000/0", c, grant_valid, grant_id, ack, wdog_err);
         else n_pass++;
         tick();
      end
      req = '0;
      tick();
   endtask
`endif

   task automatic test_random();
      int unsigned    rem [NREQ];
      logic [WID-1:0] cur [NREQ];
      logic           m_valid = 1'b0;
      int unsigned    m_holder = 0;
      int unsigned    m_ptr = 0;
      int unsigned    m_beats = 0;
      logic [NREQ-1:0] exp_ack;
      logic [IDW+WID-1:0] exp_wd;
      logic was_last;
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         rem[i] = 0;
         cur[i] = '0;
      end
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (rem[i] == 0 && $urandom_range(3) == 0) begin
               rem[i] = $urandom_range(12, 1);
               cur[i] = $urandom;
            end
            req[i]  = (rem[i] != 0);
            last[i] = (rem[i] == 1);
            data[i*WID +: WID] = cur[i];
         end
         stage_wfull = ($urandom_range(3) == 0);
         #4;
         exp_ack = (m_valid && req[m_holder] && !stage_wfull) ? (4'b0001 << m_holder) : 4'b0000;
         exp_wd  = m_valid ? {IDW'(m_holder), cur[m_holder]} : '0;
         n_total++; if (grant_valid !== m_valid) $display("FAIL rnd_gv@%0d: got %0b want %0b", c, grant_valid, m_valid); else n_pass++;
         if (m_valid) begin
            n_total++; if (grant_id !== IDW'(m_holder)) $display("FAIL rnd_gid@%0d: got %0d want %0d", c, grant_id, m_holder); else n_pass++;
         end
         n_total++; if (ack !== exp_ack) $display("FAIL rnd_ack@%0d: got %b want %b", c, ack, exp_ack); else n_pass++;
         n_total++; if (stage_writex !== (exp_ack != 0)) $display("FAIL rnd_wx@%0d: got %0b want %0b", c, stage_writex, exp_ack != 0); else n_pass++;
         n_total++; if (stage_wdata !== exp_wd) $display("FAIL rnd_wd@%0d: got %0h want %0h", c, stage_wdata, exp_wd); else n_pass++;
         n_total++; if (wdog_err !== 1'b0) $display("FAIL rnd_wdog@%0d: got %0b want 0", c, wdog_err); else n_pass++;
         if (m_valid) begin
            if (exp_ack != 0) begin
               m_beats++;
               was_last = (rem[m_holder] == 1);
               rem[m_holder]--;
               cur[m_holder] = $urandom;
               if (was_last || m_beats == MAXBURST) begin
                  m_valid = 1'b0;
                  m_ptr = (m_holder + 1) % NREQ;
               end
            end
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               if (!m_valid && req[(m_ptr + k) % NREQ]) begin
                  m_valid  = 1'b1;
                  m_holder = (m_ptr + k) % NREQ;
                  m_beats  = 0;
               end
            end
         end
         tick();
      end
      req = '0; last = '0; stage_wfull = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; req = '0; last = '0; data = '0; stage_wfull = 1'b0;
      #1;
      test_reset();
      test_two_req();
      test_stall();
      test_all_rr();
      test_maxburst();
      test_reset_mid();
      test_wfull_long();
`ifdef ROUBUS_ARB_WATCHDOG_EN
      test_watchdog();
`else
      test_idle_holder();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
